// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and dump state encoding for the register-file dump block
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_outreg.sv
// rtl/regfile_dump_outreg.sv - single-entry valid/ready output register carrying data, addr and last
module regfile_dump_outreg
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_last,
  input  logic              ready,
  output logic              room,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // The slot can take a new word when empty or when its current word leaves this cycle.
  assign room = !valid || ready;

  // Capture on load; otherwise drop valid once the held word is accepted. Contents stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      addr  <= load_addr;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - streams a window of register-file entries out through a valid/ready port
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  dump_state_e       state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [ADDR_W:0]   rem, rem_next;
  logic [ADDR_W:0]   count_sat;
  logic              done_next;
  logic              load;
  logic              room;

  // Requests longer than the register file are clipped to one full pass.
  assign count_sat = (count > MAX_CNT) ? MAX_CNT : count;

  assign busy         = (state != IDLE);
  assign rf_read_addr = (state == RUN) ? ptr : '0;

  // Next-state logic: pointer/remaining only advance when the output slot accepts a word.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    rem_next   = rem;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start && (count != '0)) begin
          state_next = RUN;
          ptr_next   = start_addr;
          rem_next   = count_sat;
        end
      end
      RUN: begin
        if (room) begin
          load     = 1'b1;
          ptr_next = ptr + 1'b1;
          rem_next = rem - ONE;
          if (rem == ONE) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer, remaining count and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      rem   <= rem_next;
      done  <= done_next;
    end
  end

  regfile_dump_outreg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(rf_read_data),
    .load_addr(ptr),
    .load_last(rem == ONE),
    .ready    (out_ready),
    .room     (room),
    .valid    (out_valid),
    .data     (out_data),
    .addr     (out_addr),
    .last     (out_last)
  );

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - table-driven scoreboard bench for regfile_dump
module tb_regfile_dump;
  import regfile_pkg::*;

  localparam int DW = DATA_W;
  localparam int AW = ADDR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          done;

  logic [DW-1:0] regs [NUM_REGS];
  assign rf_read_data = regs[rf_read_addr];

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .count       (count),
    .busy        (busy),
    .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .done        (done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW:0]   cnt;
    int            mode;
    int            exp_n;
    int            poke;
    int            wr_k;
  } vec_t;

  word_t sb[$];
  vec_t  vecs[11];
  int    tests = 0;
  int    fails = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    logic [5:0] pat;
    pat = 6'b101001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[k % 6];
      2:       return 1'($urandom_range(0, 1));
      default: return (k >= 5);
    endcase
  endfunction

  // Monitor: pops the scoreboard on each transfer, checks stall stability and counts done pulses.
  word_t held;
  logic  stall = 1'b0;
  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_addr, out_data, out_last}, {held.addr, held.data, held.last});
      end
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got addr %0d data %h last %0d, expected none", out_addr, out_data, out_last);
        end else begin
          e = sb.pop_front();
          check("word", {out_addr, out_data, out_last}, {e.addr, e.data, e.last});
        end
      end
      stall = out_valid && !out_ready;
      held  = '{out_addr, out_data, out_last};
    end
  end

  task automatic push_expected(input logic [AW-1:0] sa, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = sa + AW'(i);
      sb.push_back('{a, regs[a], (i == n - 1)});
    end
  endtask

  // Called just after a rising edge; start is seen by the following edge.
  task automatic run_dump(input vec_t v);
    int k;
    int d0;
    push_expected(v.sa, v.exp_n);
    d0         = done_cnt;
    start      = 1'b1;
    start_addr = v.sa;
    count      = v.cnt;
    out_ready  = ready_for(v.mode, 0);
    k          = 0;
    if (v.exp_n == 0) begin
      repeat (6) begin
        @(posedge clk); #1;
        start = 1'b0;
        check("noop_busy", busy, 0);
      end
    end else begin
      while (1) begin
        @(posedge clk); #1;
        k++;
        if (k == v.poke) begin
          start      = 1'b1;
          start_addr = 4'd8;
          count      = 5'd2;
        end else begin
          start = 1'b0;
        end
        if (k == 1) check("rd_addr_run", rf_read_addr, v.sa);
        if (k == v.wr_k) regs[v.sa] = 16'hBEEF;
        if (done) break;
        if (k >= 200) begin
          tests++;
          fails++;
          $display("FAIL timeout: got no done after %0d cycles, expected done", k);
          break;
        end
        out_ready = ready_for(v.mode, k);
      end
      if (v.mode == 0) check("latency", k, v.exp_n + 2);
      @(posedge clk); #1;
      check("done_pulse_width", done, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_count", done_cnt - d0, (v.exp_n > 0) ? 1 : 0);
    check("sb_empty", sb.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_rd_addr", rf_read_addr, 0);
  endtask

  initial begin
    vec_t v;
    int   d0;

    for (int i = 0; i < NUM_REGS; i++) regs[i] = DW'(16'h1000 + i * 16'h0111);
    regs[2] = 16'h1234;
    regs[3] = 16'hABCD;
    regs[4] = 16'h5555;
    regs[5] = 16'h0505;

    vecs[0]  = '{4'd2,  5'd3,  0, 3,  -1, -1};
    vecs[1]  = '{4'd14, 5'd4,  0, 4,  -1, -1};
    vecs[2]  = '{4'd0,  5'd3,  1, 3,  -1, -1};
    vecs[3]  = '{4'd5,  5'd0,  0, 0,  -1, -1};
    vecs[4]  = '{4'd7,  5'd20, 0, 16, -1, -1};
    vecs[5]  = '{4'd9,  5'd16, 2, 16, -1, -1};
    vecs[6]  = '{4'd15, 5'd1,  0, 1,  -1, -1};
    vecs[7]  = '{4'd0,  5'd4,  0, 4,  2,  -1};
    vecs[8]  = '{4'd5,  5'd2,  3, 2,  -1, 2};
    vecs[9]  = '{4'd5,  5'd1,  0, 1,  -1, -1};
    vecs[10] = '{4'd3,  5'd7,  1, 7,  -1, -1};

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_addr", rf_read_addr, 0);
    check("rst_outs", {out_valid, out_data, out_addr, out_last, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      run_dump(vecs[i]);
    end

    // Reset after the second transfer of an 8-word dump.
    @(posedge clk); #1;
    v = '{4'd1, 5'd8, 0, 8, -1, -1};
    push_expected(v.sa, v.exp_n);
    d0         = done_cnt;
    start      = 1'b1;
    start_addr = v.sa;
    count      = v.cnt;
    out_ready  = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst_popped", sb.size(), 6);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rd_addr", rf_read_addr, 0);
    check("midrst_outs", {out_valid, out_data, out_addr, out_last, done}, 0);
    sb.delete();
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_valid_low", out_valid, 0);
    end
    check("midrst_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    v = '{4'd10, 5'd5, 0, 5, -1, -1};
    run_dump(v);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter DATA_W, 16, register data width in bits.
REQ-002 Parameter ADDR_W, 4, register address width in bits (NUM_REGS = 2**ADDR_W = 16).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  dump request; sampled only in IDLE.
REQ-006 Port start_addr  input  ADDR_W  first register to read.
REQ-007 Port count  input  ADDR_W+1  number of registers to read; 0 = no-op; values above 16 are treated as 16.
REQ-008 Port busy  output  1  high whenever the state is not IDLE.
REQ-009 Port rf_read_addr  output  ADDR_W  drives one register-file read port.
REQ-010 Port rf_read_data  input  DATA_W  combinational read data for rf_read_addr, valid in the same cycle.
REQ-011 Port out_valid  output  1  output word valid.
REQ-012 Port out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid && out_ready.
REQ-013 Port out_data  output  DATA_W  register contents.
REQ-014 Port out_addr  output  ADDR_W  register index of out_data.
REQ-015 Port out_last  output  1  high with the final word of a dump.
REQ-016 Port done  output  1  one-cycle pulse after the final transfer.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN SHALL occur on the edge where start=1 and count!=0; this loads ptr=start_addr and rem=min(count,16).
REQ-019 start with count=0 SHALL be ignored: no state change, no output, no done.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 rf_read_addr SHALL equal ptr in RUN and SHALL hold 0 in IDLE and DRAIN.
REQ-022 In RUN, the output register SHALL load {rf_read_data, ptr, rem==1} when it is empty or a transfer occurs in the same cycle. On that load, ptr SHALL increment modulo 16 (15 wraps to 0) and rem SHALL decrement.
REQ-023 While the output register is full and out_ready=0, out_data, out_addr and out_last SHALL hold stable, and ptr and rem SHALL not change.
REQ-024 When the load with rem==1 occurs, the FSM SHALL move RUN->DRAIN.
REQ-025 In DRAIN, the transfer of the out_last word SHALL pulse done in the next cycle and return the FSM to IDLE.
REQ-026 Latency SHALL be: start accepted at edge N; first word presented at edge N+1; out_valid high from cycle N+2.
REQ-027 With out_ready held at 1, throughput SHALL be one word per cycle, and an n-word dump SHALL take n+2 cycles from start to done.
REQ-028 out_data SHALL be the register value sampled in the load cycle; later register-file writes SHALL not alter a word already loaded.
REQ-029 out_valid SHALL never drop without a transfer.
REQ-030 A start is ignored while busy (including the done cycle if busy is still high); a start in the cycle after done SHALL be accepted.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, ptr=0, rem=0, and all outputs to 0: busy, rf_read_addr, out_valid, out_data, out_addr, out_last, done.
REQ-032 Reset asserted mid-dump SHALL abandon the dump, with no done pulse and no further output words.
REQ-033 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-034 Package regfile_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS and the dump state enum (IDLE, RUN, DRAIN).
REQ-035 The output stage SHALL be one sub-module, regfile_dump_outreg: a single-entry valid/ready register carrying data, addr and last.
REQ-036 The FSM, ptr and rem SHALL stay in regfile_dump.

Verification
REQ-037 Basic dump: regs 2=0x1234, 3=0xABCD, 4=0x5555; start_addr=2, count=3, out_ready=1 -> words (2,0x1234),(3,0xABCD),(4,0x5555,last) on consecutive cycles, then done one cycle later.
REQ-038 Wrap: start_addr=14, count=4 -> out_addr sequence 14,15,0,1, with last on addr 1.
REQ-039 Backpressure: count=3, out_ready toggled 1,0,0,1,0,1... -> no word lost or duplicated, data stable while stalled, exactly 3 transfers, one done pulse.
REQ-040 Boundaries: count=0 -> busy stays 0 and no done; count=20 -> exactly 16 words; start during busy -> ignored.
REQ-041 Reset mid-dump: assert rst_n=0 after the 2nd transfer of an 8-word dump -> outputs 0 immediately, no done; a new dump afterwards runs correctly.
REQ-042 Snapshot: write reg 5=0xBEEF during the cycle after reg 5 is loaded -> out_data shows the old value.
